// File: rtl/dsm_interp_feeder.sv
// dsm_interp_feeder: linear interpolator turning synth-rate samples into one dsm word per rdreq.
// Latency: data_out changes the cycle after rdreq; a queued sample becomes the target C at the next wrap.
// Backpressure: one-entry buffer, in_ready = ~bf; it stays low until the next interval wrap drains it.
module dsm_interp_feeder #(
   parameter int OSR_LOG2 = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        rdreq,
   output logic [15:0] data_out,
   output logic        underrun
);

   localparam int AW = 17 + OSR_LOG2;

   logic [15:0]         p_q;       // previous sample (interval start)
   logic [15:0]         c_q;       // target sample (interval end)
   logic [15:0]         b_q;       // one-entry input buffer
   logic                bf_q;      // buffer full flag
   logic [AW-1:0]       acc_q;     // scaled interpolation accumulator
   logic [OSR_LOG2-1:0] k_q;       // step counter within the interval

   logic [16:0]         delta;
   logic [AW-1:0]       acc_step;
   logic [AW-1:0]       acc_base;
   logic                wrap;
   logic                accept;

   // Delta is not stored: every wrap sets P to the old C, so C-P always equals
   // the per-interval delta (zero after an underrun, since then P == C).
   always_comb begin
      delta    = {c_q[15], c_q} - {p_q[15], p_q};
      acc_step = acc_q + {{OSR_LOG2{delta[16]}}, delta};
      acc_base = {c_q[15], c_q, {OSR_LOG2{1'b0}}};
      wrap     = rdreq & (&k_q);
      accept   = in_valid & ~bf_q;
   end

   // Ready depends on the registered flag only, never on in_valid or rdreq.
   assign in_ready = ~bf_q;

   // Input buffer: filled on handshake, drained only by a wrap that finds it full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         b_q  <= '0;
         bf_q <= 1'b0;
      end else begin
         if (accept) begin
            b_q  <= in_data;
            bf_q <= 1'b1;
         end else if (wrap && bf_q) begin
            bf_q <= 1'b0;
         end
      end
   end

   // Interpolator: each rdreq either advances one step or wraps to the next interval.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_q      <= '0;
         c_q      <= '0;
         acc_q    <= '0;
         k_q      <= '0;
         data_out <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (rdreq) begin
            if (wrap) begin
               k_q      <= '0;
               p_q      <= c_q;
               acc_q    <= acc_base;
               data_out <= c_q;
               if (bf_q) begin
                  c_q <= b_q;
               end else begin
                  underrun <= 1'b1;
               end
            end else begin
               k_q      <= k_q + OSR_LOG2'(1);
               acc_q    <= acc_step;
               // floor(acc/2^OSR_LOG2), low 16 bits: stays within [P, C]
               data_out <= acc_step[OSR_LOG2+15:OSR_LOG2];
            end
         end
      end
   end

endmodule

// File: tb/tb_dsm_interp_feeder.sv
// tb_dsm_interp_feeder: directed bench for dsm_interp_feeder at OSR_LOG2=2.
// A sample-level model (queue of accepted samples, endpoint interpolation by formula) is compared every cycle.
// Hand-computed literal tables pin the model and cover startup, full-scale, underrun, ordering and async reset.
module tb_dsm_interp_feeder;

   localparam int OSR = 2;
   localparam int N   = 4;

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b1;
   logic [15:0] in_data  = '0;
   logic        in_valid = 1'b0;
   logic        rdreq    = 1'b0;
   logic        in_ready;
   logic [15:0] data_out;
   logic        underrun;

   always #5 clk = ~clk;

   dsm_interp_feeder #(.OSR_LOG2(OSR)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .rdreq    (rdreq),
      .data_out (data_out),
      .underrun (underrun)
   );

   int checks = 0;
   int passes = 0;
   int stalls = 0;
   int last_un = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- sample-level model ----------------
   int m_prev = 0;
   int m_cur  = 0;
   int m_j    = 0;
   int m_out  = 0;
   int m_un   = 0;
   bit m_take = 1'b0;
   int m_q[$];

   function automatic int floordiv(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   // Output at read j of an interval is prev + floor((cur-prev)*j/N).
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_prev = 0; m_cur = 0; m_j = 0; m_out = 0; m_un = 0;
         m_q.delete();
      end else begin
         m_take = in_valid && (m_q.size() == 0);
         m_un = 0;
         if (rdreq) begin
            if (m_j < N - 1) begin
               m_j++;
               m_out = m_prev + floordiv((m_cur - m_prev) * m_j, N);
            end else begin
               m_j = 0;
               m_prev = m_cur;
               if (m_q.size() > 0) m_cur = m_q.pop_front();
               else m_un = 1;
               m_out = m_prev;
            end
         end
         if (m_take) m_q.push_back(int'($signed(in_data)));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_data_out", int'($signed(data_out)), m_out);
         check("cyc_underrun", int'(underrun), m_un);
         check("cyc_in_ready", int'(in_ready), int'(m_q.size() == 0));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Returns the word consumed by this rdreq and underrun right after the edge.
   task automatic consume(output int v, output int un);
      v = $signed(data_out);
      rdreq = 1'b1;
      @(posedge clk); #1;
      rdreq = 1'b0;
      un = int'(underrun);
   endtask

   task automatic rd_chk(input string name, input int exp);
      int v;
      int un;
      consume(v, un);
      last_un = un;
      check(name, v, exp);
   endtask

   task automatic push(input int v);
      int n;
      n = 0;
      in_data  = 16'(v);
      in_valid = 1'b1;
      while (n < 100) begin
         @(negedge clk);
         if (in_ready) break;
         stalls++;
         n++;
      end
      if (n >= 100) check("push_accept_timeout", 0, 1);
      else tick();
      in_valid = 1'b0;
   endtask

   int vals [6]  = '{400, -400, 1200, 8, -8, 0};
   int exp4 [29] = '{0, 0, 0, 0, 0, 100, 200, 300, 400, 200, 0, -200,
                     -400, 0, 400, 800, 1200, 902, 604, 306,
                     8, 4, 0, -4, -8, -6, -4, -2, 0};
   int got [29];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      #2 reset_n = 1'b0;
      chk_en = 1'b1;
      tick(); tick();
      check("rst_data_out", int'(data_out), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #3 reset_n = 1'b1;
      tick();

      // startup: 400 queued, four flat reads, then ramp, with -400 queued
      push(400);
      for (int i = 0; i < 4; i++) rd_chk("t1_lead", 0);
      push(-400);
      rd_chk("t1_up0", 0);   rd_chk("t1_up1", 100);
      rd_chk("t1_up2", 200); rd_chk("t1_up3", 300);
      push(32767);
      rd_chk("t1_dn0", 400); rd_chk("t1_dn1", 200);
      rd_chk("t1_dn2", 0);   rd_chk("t1_dn3", -200);
      push(-32768);
      rd_chk("t2_ramp0", -400);  rd_chk("t2_ramp1", 7891);
      rd_chk("t2_ramp2", 16183); rd_chk("t2_ramp3", 24475);
      // full-scale step 32767 -> -32768; queue empty at the wrap
      rd_chk("t2_fs0", 32767); rd_chk("t2_fs1", 16383);
      rd_chk("t2_fs2", -1);    rd_chk("t2_fs3", -16385);
      check("t3_under_hi", last_un, 1);
      tick();
      check("t3_under_pulse", int'(underrun), 0);
      for (int i = 0; i < 4; i++) rd_chk("t3_hold", -32768);
      check("t3_under_again", last_un, 1);
      push(1000);
      for (int i = 0; i < 4; i++) rd_chk("t3_hold2", -32768);
      check("t3_no_under", last_un, 0);
      rd_chk("t3_resume0", -32768); rd_chk("t3_resume1", -24326);
      rd_chk("t3_resume2", -15884); rd_chk("t3_resume3", -7442);
      check("t3_under_end", last_un, 1);

      // sample accepted on the same edge as an empty wrap
      for (int i = 0; i < 3; i++) rd_chk("t5_flat", 1000);
      in_data  = 16'(2000);
      in_valid = 1'b1;
      check("t5_ready", int'(in_ready), 1);
      rd_chk("t5_flat", 1000);
      in_valid = 1'b0;
      check("t5_under", last_un, 1);
      check("t5_buffered", int'(in_ready), 0);
      for (int i = 0; i < 4; i++) rd_chk("t5_flat2", 1000);
      check("t5_no_under", last_un, 0);
      rd_chk("t5_ramp0", 1000); rd_chk("t5_ramp1", 1250);

      // async reset mid-ramp (K=2) with a sample buffered
      push(3000);
      check("t6_pre_ready", int'(in_ready), 0);
      check("t6_pre_data", int'($signed(data_out)), 1500);
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_data", int'(data_out), 0);
      check("t6_async_under", int'(underrun), 0);
      check("t6_async_ready", int'(in_ready), 1);
      tick();
      @(posedge clk); #3 reset_n = 1'b1;
      tick();

      // startup again, in_valid held high continuously
      stalls = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) push(vals[i]);
         end
         begin
            for (int i = 0; i < 29; i++) begin
               int v;
               int un;
               consume(v, un);
               got[i] = v;
            end
         end
      join
      for (int i = 0; i < 29; i++) check("t4_stream", got[i], exp4[i]);
      for (int n = 0; n < 6; n++) check("t4_order", got[4 * n + 8], vals[n]);
      check("t4_stalled", int'(stalls > 0), 1);

      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/dsm_interp_feeder.md
Name: dsm_interp_feeder

Overview:
- Upstream feeder for the delta-sigma modulator (dsm).
- Accepts signed 16-bit audio samples at the synth sample rate over a valid/ready handshake.
- Linearly interpolates between consecutive samples to the modulator's read rate, presenting one interpolated word per modulator rdreq on the dsm data_in bus.
- Sits between the synth voice mixer and dsm.

Parameters:
- OSR_LOG2, 6: log2 of rdreq pulses per input sample; number of interpolation steps = 2^OSR_LOG2. Legal range 1..10.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- in_data  input  16  signed input sample, two's complement
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data this cycle
- rdreq  input  1  dsm consume strobe, single-cycle pulses
- data_out  output  16  signed interpolated sample; drives dsm data_in
- underrun  output  1  one-cycle pulse: interval ended with no queued sample

Behaviour:
- Storage and registers:
  - P: previous sample, 16 b signed.
  - C: target sample, 16 b signed.
  - D: delta = C-P, 17 b signed.
  - ACC: 17+OSR_LOG2 b signed.
  - K: step counter, OSR_LOG2 b.
  - One-entry input buffer B with flag bf.
- Reset (async, reset_n low): P=C=D=ACC=K=0, bf=0, data_out=0, underrun=0, in_ready=1. Deassertion is synchronised by the integrator; the block just samples reset_n asynchronously.
- Input handshake:
  - in_ready = ~bf, driven combinationally from the registered flag only.
  - No path from in_valid or rdreq to in_ready.
  - Transfer occurs on an edge where in_valid & in_ready: B<=in_data, bf<=1.
- Show-ahead output:
  - data_out always holds the word dsm will consume next.
  - It is updated only on an edge where rdreq=1, so it is stable between rdreqs.
  - Latency: the new value is visible the cycle after rdreq.
- Interpolation step (edge with rdreq=1, K != 2^OSR_LOG2-1):
  - ACC <= ACC+D; K <= K+1.
  - data_out <= (ACC+D) >>> OSR_LOG2, arithmetic shift with floor rounding, low 16 b.
  - The result always lies between P and C inclusive, so no saturation is needed.
- Interval wrap (edge with rdreq=1, K == 2^OSR_LOG2-1): K<=0 and P<=C.
  - If bf=1: C<=B, bf<=0, D<=B-C (17 b), ACC<=C<<OSR_LOG2, data_out<=C.
  - If bf=0: C unchanged, D<=0, ACC<=C<<OSR_LOG2, data_out<=C, underrun=1 for that one cycle. Output holds flat at C until a later interval finds a sample.
- Simultaneous events:
  - in_valid accepted on the same edge as a wrap with bf=0: the sample is written to B, the wrap still counts as an underrun, and B is used at the next wrap. There is no bypass.
  - rdreq while in_ready: the two operations are independent and both take effect.
- Consecutive rdreq cycles are legal; each one advances one step.
- Startup: the first accepted sample enters B and becomes C at the first wrap. The output is 0 for the first 2^OSR_LOG2 reads, then ramps from 0.
- Reset mid-interval: everything clears immediately; the buffered sample is lost.

Test Plan:
- OSR_LOG2=2; reset; push 400; issue 4 rdreq -> data_out stays 0. Next 4 rdreq -> 0,100,200,300. The next 4, with -400 queued -> 400,200,0,-200.
- OSR_LOG2=2; full-scale step P=32767, C=-32768 -> 32767,16383,-1,-16385, then -32768. No wrap or overflow.
- Queue empty at wrap -> underrun high exactly 1 cycle, data_out held constant at C for the next 4 rdreq. A sample pushed later resumes the ramp at the following wrap.
- in_valid held high continuously -> in_ready low while bf=1. Exactly one sample is accepted per interval, with no drops or duplicates; check order against a scoreboard.
- in_valid accepted on the same cycle as a wrap with bf=0 -> underrun=1 that cycle, and the sample becomes C at the next wrap.
- Assert reset_n low mid-ramp (K=2), asynchronous to clk -> all outputs 0 and in_ready=1 without waiting for a clock edge. After release, the startup sequence repeats.
